// File: rtl/psram_op_arbiter.sv
// Purpose : chip-init sequencer plus round-robin arbiter between two requesters
//           (port 0 = capture writer, port 1 = readback/upload) and the Octal
//           PSRAM operator's Op_Code/Op_Done handshake, with a hung-op watchdog.
// Latency : request sampled in IDLE -> operator code next cycle -> oAckN one
//           cycle after iOp_Done. An illegal op is acked the cycle after sampling.
// Backpressure: requesters hold iReqN with stable fields until oAckN. Only one
//           op is in flight, and oOp_Code stays 0 for GAP_CYC cycles between ops.
// Ports   : iClk/iRst       clock, synchronous active-high reset
//           iReqN/iOpN/iAddrN/iDataN, oAckN   requester side (N = 0, 1)
//           oRdData         read data, valid in the oAck cycle of a read
//           oReady/oErr     init done / sticky timeout flag
//           oOp_Code/oAddress/oData, iOp_Done/iData_o   operator side
module psram_op_arbiter #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int GAP_CYC     = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq0,
  input  logic [2:0]  iOp0,
  input  logic [31:0] iAddr0,
  input  logic [15:0] iData0,
  output logic        oAck0,
  input  logic        iReq1,
  input  logic [2:0]  iOp1,
  input  logic [31:0] iAddr1,
  input  logic [15:0] iData1,
  output logic        oAck1,
  output logic [15:0] oRdData,
  output logic        oReady,
  output logic        oErr,
  output logic [2:0]  oOp_Code,
  input  logic        iOp_Done,
  output logic [31:0] oAddress,
  output logic [15:0] oData,
  input  logic [15:0] iData_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(GAP_CYC - 1);

  localparam logic [2:0] S_INIT_RST = 3'd0;
  localparam logic [2:0] S_INIT_MR  = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_RST  = 3'd1;
  localparam logic [2:0] OP_MR   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd4;
  localparam logic [2:0] OP_RD   = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      r_gap_next;   // state entered when the gap expires
  logic [GP_W-1:0] r_gap;
  logic [WD_W-1:0] r_wd;
  logic            r_last;       // port granted last; reset value 1 favours port 0
  logic            r_win;
  logic            r_ack0;
  logic            r_ack1;
  logic [15:0]     r_rd;
  logic            r_ready;
  logic            r_err;
  logic [2:0]      r_code;
  logic [31:0]     r_addr;
  logic [15:0]     r_data;

  logic            w_win;
  logic [2:0]      w_op;
  logic            w_legal;
  logic            w_acking;
  logic            w_wd_hit;

  // Both requesting: the port not granted last wins; otherwise the lone requester.
  assign w_win    = (iReq0 & iReq1) ? ~r_last : iReq1;
  assign w_op     = w_win ? iOp1 : iOp0;
  assign w_legal  = (w_op == OP_WR) || (w_op == OP_RD);
  // A requester drops iReq during its ack cycle, so IDLE must not sample then.
  assign w_acking = r_ack0 | r_ack1;
  assign w_wd_hit = (r_wd == WD_LAST);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_INIT_RST;
      r_gap_next <= S_INIT_RST;
      r_gap      <= '0;
      r_wd       <= '0;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rd       <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= OP_NONE;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_INIT_RST, S_INIT_MR: begin
          if (r_code == OP_NONE) begin
            // Only reachable straight out of reset: launch the init command.
            r_code <= (r_state == S_INIT_RST) ? OP_RST : OP_MR;
            r_wd   <= '0;
          end else if (iOp_Done) begin
            r_code     <= OP_NONE;
            r_state    <= S_GAP;
            r_gap      <= GAP_LAST;
            r_gap_next <= (r_state == S_INIT_RST) ? S_INIT_MR : S_IDLE;
            r_wd       <= '0;
          end else if (w_wd_hit) begin
            r_code     <= OP_NONE;
            r_err      <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= S_GAP;
            r_gap      <= GAP_LAST;
            r_gap_next <= S_INIT_RST;
            r_wd       <= '0;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_IDLE: begin
          if ((iReq0 | iReq1) && !w_acking) begin
            r_win  <= w_win;
            r_addr <= w_win ? iAddr1 : iAddr0;
            r_data <= w_win ? iData1 : iData0;
            if (w_legal) begin
              r_code  <= w_op;
              r_state <= S_RUN;
              r_wd    <= '0;
            end else begin
              // Illegal op: acknowledge without touching the operator or the gap.
              r_ack0 <= ~w_win;
              r_ack1 <= w_win;
              r_last <= w_win;
            end
          end
        end
        S_RUN: begin
          if (iOp_Done) begin
            r_ack0     <= ~r_win;
            r_ack1     <= r_win;
            if (r_code == OP_RD) r_rd <= iData_o;
            r_last     <= r_win;
            r_code     <= OP_NONE;
            r_state    <= S_GAP;
            r_gap      <= GAP_LAST;
            r_gap_next <= S_IDLE;
            r_wd       <= '0;
          end else if (w_wd_hit) begin
            // Hung operator: release the requester, then re-initialise the chip.
            r_ack0     <= ~r_win;
            r_ack1     <= r_win;
            r_code     <= OP_NONE;
            r_err      <= 1'b1;
            r_ready    <= 1'b0;
            r_state    <= S_GAP;
            r_gap      <= GAP_LAST;
            r_gap_next <= S_INIT_RST;
            r_wd       <= '0;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= r_gap_next;
            r_wd    <= '0;
            case (r_gap_next)
              S_INIT_RST: r_code  <= OP_RST;
              S_INIT_MR:  r_code  <= OP_MR;
              default:    r_ready <= 1'b1;
            endcase
          end else begin
            r_gap <= r_gap - GP_W'(1);
          end
        end
        default: begin
          r_state <= S_INIT_RST;
          r_code  <= OP_NONE;
        end
      endcase
    end
  end

  assign oAck0    = r_ack0;
  assign oAck1    = r_ack1;
  assign oRdData  = r_rd;
  assign oReady   = r_ready;
  assign oErr     = r_err;
  assign oOp_Code = r_code;
  assign oAddress = r_addr;
  assign oData    = r_data;

endmodule

// File: tb/tb_psram_op_arbiter.sv
// Purpose : bench for psram_op_arbiter with an operator model, two requesters,
//           a run-length monitor of oOp_Code and a transaction-level reference.
// Latency : n/a (bench)
// Backpressure: requesters hold iReqN until oAckN, bounded by a cycle budget.
module tb_psram_op_arbiter;
  localparam int TO     = 16;
  localparam int GAP    = 2;
  localparam int INIT_D = 5;

  logic        iClk, iRst;
  logic        iReq0, iReq1, oAck0, oAck1;
  logic [2:0]  iOp0, iOp1, oOp_Code;
  logic [31:0] iAddr0, iAddr1, oAddress;
  logic [15:0] iData0, iData1, oRdData, oData, iData_o;
  logic        oReady, oErr, iOp_Done;

  psram_op_arbiter #(.TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReq0(iReq0), .iOp0(iOp0), .iAddr0(iAddr0), .iData0(iData0), .oAck0(oAck0),
    .iReq1(iReq1), .iOp1(iOp1), .iAddr1(iAddr1), .iData1(iData1), .oAck1(oAck1),
    .oRdData(oRdData), .oReady(oReady), .oErr(oErr),
    .oOp_Code(oOp_Code), .iOp_Done(iOp_Done), .oAddress(oAddress), .oData(oData),
    .iData_o(iData_o)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // ---------------- operator model ----------------
  int          op_delay = INIT_D;
  bit          op_hang  = 0;
  logic [15:0] op_mem [logic [31:0]];
  logic [2:0]  op_last_code;
  logic [31:0] op_last_addr;
  logic [15:0] op_last_data;

  initial begin
    logic [2:0]  c;
    logic [31:0] a;
    logic [15:0] d;
    int          dl;
    bit          aborted;
    iOp_Done = 1'b0;
    iData_o  = '0;
    forever begin
      @(negedge iClk);
      if (!iRst && oOp_Code != 3'd0 && !op_hang) begin
        c = oOp_Code; a = oAddress; d = oData; dl = op_delay; aborted = 0;
        op_last_code = c; op_last_addr = a; op_last_data = d;
        for (int i = 1; i < dl && !aborted; i++) begin
          @(negedge iClk);
          if (oOp_Code == 3'd0) aborted = 1;
          else begin
            chk("op_code_hold", oOp_Code, c);
            chk("op_addr_hold", oAddress, a);
            chk("op_data_hold", oData, d);
          end
        end
        if (!aborted) begin
          if (c == 3'd4) op_mem[a] = d;
          if (c == 3'd5) iData_o = op_mem.exists(a) ? op_mem[a] : dflt(a);
          else           iData_o = 16'($urandom);
          iOp_Done = 1'b1;
          @(negedge iClk);
          iOp_Done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor: code run lengths, acks ----------------
  int cyc = 0;
  int cur_code = 0, cur_len = 0;
  int rq_code[$], rq_len[$];
  int nz_start = 0, nz_total = 0;
  int ack0_n = 0, ack1_n = 0;
  int glog[$];
  int rdy_cyc = 0;

  initial forever begin
    @(posedge iClk);
    #1;
    if (iRst) begin
      cyc = 0; cur_code = 0; cur_len = 0;
      rq_code.delete(); rq_len.delete();
    end else begin
      cyc++;
      if (int'(oOp_Code) == cur_code) cur_len++;
      else begin
        if (cur_len > 0) begin rq_code.push_back(cur_code); rq_len.push_back(cur_len); end
        if (oOp_Code != 3'd0) nz_start = cyc;
        cur_code = int'(oOp_Code);
        cur_len  = 1;
      end
      if (oOp_Code != 3'd0) nz_total++;
      if (oAck0 || oAck1) begin
        chk("dual_ack", oAck0 & oAck1, 0);
        if (oAck0) begin ack0_n++; glog.push_back(0); end
        if (oAck1) begin ack1_n++; glog.push_back(1); end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [logic [31:0]];
  logic [15:0] ref_rd  = '0;
  int          ref_last = 1;

  task automatic model_apply(input int p, input logic [2:0] op, input logic [31:0] a,
                             input logic [15:0] d, output logic [15:0] exp);
    if (op == 3'd4) begin
      ref_mem[a] = d;
      ref_last = p;
    end else if (op == 3'd5) begin
      ref_rd = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      ref_last = p;
    end
    exp = ref_rd;
  endtask

  // ---------------- requester / helpers ----------------
  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [15:0] d, output int rc, output int ac, output logic [15:0] rd);
    bit got = 0;
    ac = -1; rd = '0;
    @(negedge iClk);
    if (p == 0) begin iReq0 = 1; iOp0 = op; iAddr0 = a; iData0 = d; end
    else        begin iReq1 = 1; iOp1 = op; iAddr1 = a; iData1 = d; end
    rc = cyc;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge iClk);
      if ((p == 0 && oAck0) || (p == 1 && oAck1)) begin
        got = 1; ac = cyc; rd = oRdData;
      end
    end
    if (p == 0) iReq0 = 0; else iReq1 = 0;
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_ready(input string tag);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge iClk);
      if (oReady) begin got = 1; rdy_cyc = cyc; end
    end
    chk(tag, got, 1);
  endtask

  task automatic check_init(input int base, input bit chk_rdy);
    if (rq_code.size() < base + 3) chk("init_runs", rq_code.size(), base + 3);
    else begin
      chk("init_rst_code", rq_code[base], 1);
      chk("init_rst_len",  rq_len[base], INIT_D);
      chk("init_gap_code", rq_code[base+1], 0);
      chk("init_gap_len",  rq_len[base+1], GAP);
      chk("init_mr_code",  rq_code[base+2], 2);
      chk("init_mr_len",   rq_len[base+2], INIT_D);
      if (chk_rdy) chk("ready_cyc", rdy_cyc, 1 + 2*INIT_D + 2*GAP);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  int          rc, ac, a0, nzt, gb, idx, w;
  int          nx[2];
  logic [15:0] rd, e, e0, e1;
  int          crc[4], cac[4];
  logic [15:0] crd[4];
  logic [2:0]  ro[2];
  logic [31:0] ra[2];
  logic [15:0] rdd[2];
  int          rrc[2], rac[2];
  logic [15:0] rrd[2];

  initial begin
    iRst = 1; iReq0 = 0; iReq1 = 0; iOp0 = 0; iOp1 = 0;
    iAddr0 = 0; iAddr1 = 0; iData0 = 0; iData1 = 0;
    op_mem[32'h10] = 16'hA55A; ref_mem[32'h10] = 16'hA55A;
    repeat (3) @(negedge iClk);
    chk("rst_ack0", oAck0, 0);     chk("rst_ack1", oAck1, 0);
    chk("rst_rddata", oRdData, 0); chk("rst_ready", oReady, 0);
    chk("rst_err", oErr, 0);       chk("rst_code", oOp_Code, 0);
    chk("rst_addr", oAddress, 0);  chk("rst_data", oData, 0);
    iRst = 0;
    wait_ready("init_ready");
    check_init(0, 1);

    // single write on port 0, operator takes 8 cycles
    op_delay = 8;
    a0 = ack0_n;
    issue(0, 3'd4, 32'h0, 16'h7777, rc, ac, rd);
    chk("wr_code_lat", nz_start, rc + 1);
    chk("wr_code", op_last_code, 4);
    chk("wr_addr", op_last_addr, 32'h0);
    chk("wr_data", op_last_data, 16'h7777);
    chk("wr_hold_len", rq_len.size() > 0 ? rq_len[rq_len.size()-1] : -1, 8);
    chk("wr_ack_lat", ac, nz_start + 8);
    chk("wr_gap0", oOp_Code, 0);
    @(negedge iClk);
    chk("wr_gap1", oOp_Code, 0);
    chk("wr_ack_pulse", oAck0, 0);
    chk("wr_ack_count", ack0_n, a0 + 1);
    model_apply(0, 3'd4, 32'h0, 16'h7777, e);
    chk("wr_rddata", rd, e);

    // single read on port 1
    op_delay = INIT_D;
    issue(1, 3'd5, 32'h10, 16'h0, rc, ac, rd);
    model_apply(1, 3'd5, 32'h10, 16'h0, e);
    chk("rd_data", rd, 16'hA55A);
    chk("rd_ack_lat", ac, nz_start + INIT_D);

    // both ports held high for four ops: strict alternation
    gb = glog.size();
    fork
      begin
        issue(0, 3'd4, 32'h100, 16'hC000, crc[0], cac[0], crd[0]);
        issue(0, 3'd4, 32'h104, 16'hC001, crc[1], cac[1], crd[1]);
      end
      begin
        issue(1, 3'd4, 32'h110, 16'hC100, crc[2], cac[2], crd[2]);
        issue(1, 3'd4, 32'h114, 16'hC101, crc[3], cac[3], crd[3]);
      end
    join
    chk("rr_count", glog.size() - gb, 4);
    nx[0] = 0; nx[1] = 0;
    for (int k = 0; k < 4; k++) begin
      w = 1 - ref_last;
      if (glog.size() > gb + k) chk("rr_grant", glog[gb+k], w);
      model_apply(w, 3'd4, 32'h100 + 32'(16*w + 4*nx[w]), 16'hC000 | 16'(w << 8) | 16'(nx[w]), e);
      nx[w]++;
    end

    // randomized single and contended traffic
    for (int it = 0; it < 16; it++) begin
      op_delay = $urandom_range(1, 10);
      for (int p = 0; p < 2; p++) begin
        ro[p]  = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'd5;
        ra[p]  = 32'($urandom_range(0, 15)) << 2;
        rdd[p] = 16'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        fork
          issue(0, ro[0], ra[0], rdd[0], rrc[0], rac[0], rrd[0]);
          issue(1, ro[1], ra[1], rdd[1], rrc[1], rac[1], rrd[1]);
        join
        w = 1 - ref_last;
        model_apply(w, ro[w], ra[w], rdd[w], e0);
        model_apply(1 - w, ro[1-w], ra[1-w], rdd[1-w], e1);
        chk("rnd_rd_first", rrd[w], e0);
        chk("rnd_rd_second", rrd[1-w], e1);
        chk("rnd_rr_order", rac[w] < rac[1-w], 1);
      end else begin
        w = $urandom_range(0, 1);
        issue(w, ro[w], ra[w], rdd[w], rrc[0], rac[0], rrd[0]);
        model_apply(w, ro[w], ra[w], rdd[w], e);
        chk("rnd_rd_single", rrd[0], e);
      end
    end

    // hung operator: watchdog aborts, acks, flags error and re-initialises
    op_delay = INIT_D;
    op_hang  = 1;
    issue(0, 3'd5, 32'h20, 16'h0, rc, ac, rd);
    op_hang  = 0;
    idx = rq_code.size();
    chk("to_code", idx > 0 ? rq_code[idx-1] : -1, 5);
    chk("to_len",  idx > 0 ? rq_len[idx-1]  : -1, TO);
    chk("to_ack_lat", ac, nz_start + TO);
    chk("to_err", oErr, 1);
    chk("to_ready_low", oReady, 0);
    chk("to_rddata", rd, ref_rd);
    wait_ready("to_reinit_ready");
    chk("to_gap_len", rq_len.size() > idx ? rq_len[idx] : -1, GAP);
    check_init(idx + 1, 0);
    chk("to_err_sticky", oErr, 1);

    // reset in the middle of an op: no ack, code drops, init restarts
    op_delay = 12;
    @(negedge iClk);
    iReq0 = 1; iOp0 = 3'd4; iAddr0 = 32'h40; iData0 = 16'h1234;
    for (int i = 0; i < 20 && oOp_Code == 3'd0; i++) @(negedge iClk);
    chk("rst_run_started", oOp_Code, 4);
    repeat (3) @(negedge iClk);
    a0 = ack0_n;
    iRst = 1; iReq0 = 0; op_delay = INIT_D;
    @(negedge iClk);
    chk("midrst_code", oOp_Code, 0);
    chk("midrst_ack", oAck0, 0);
    chk("midrst_ready", oReady, 0);
    chk("midrst_err", oErr, 0);
    iRst = 0;
    wait_ready("midrst_ready_again");
    chk("midrst_no_ack", ack0_n, a0);
    check_init(0, 1);
    ref_last = 1; ref_rd = '0;

    // illegal op: acked next cycle, operator never sees a code
    nzt = nz_total;
    a0  = ack0_n;
    issue(0, 3'd2, 32'h80, 16'hDEAD, rc, ac, rd);
    chk("ill_ack_lat", ac, rc + 1);
    chk("ill_rddata", rd, ref_rd);
    repeat (4) @(negedge iClk);
    chk("ill_no_code", nz_total, nzt);
    chk("ill_ack_count", ack0_n, a0 + 1);

    // read back a contended write after the re-init
    issue(1, 3'd5, 32'h114, 16'h0, rc, ac, rd);
    model_apply(1, 3'd5, 32'h114, 16'h0, e);
    chk("final_read", rd, e);

    repeat (2) @(negedge iClk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
